nasti_mem_slave: RTL and testbench

NASTI_MEM_SLAVE -- requirements
Module: nasti_mem_slave

---
 rtl/nasti_mem_slave_if.sv | 70 +++++++
 rtl/nasti_mem_slave.sv | 186 ++++++++++++++++++
 tb/tb_nasti_mem_slave.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nasti_mem_slave_if.sv
// AXI4 (NASTI) channel bundle used between a master and the memory responder.
// Only the fields the responder consumes or produces are carried.
interface nasti_if #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int C_NASTI_USER_WIDTH = 1
);
    logic [C_NASTI_ID_WIDTH-1:0]     aw_id;
    logic [C_NASTI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                      aw_len;
    logic [2:0]                      aw_size;
    logic [1:0]                      aw_burst;
    logic                            aw_valid;
    logic                            aw_ready;

    logic [C_NASTI_DATA_WIDTH-1:0]   w_data;
    logic [C_NASTI_DATA_WIDTH/8-1:0] w_strb;
    logic                            w_last;
    logic                            w_valid;
    logic                            w_ready;

    logic [C_NASTI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                      b_resp;
    logic [C_NASTI_USER_WIDTH-1:0]   b_user;
    logic                            b_valid;
    logic                            b_ready;

    logic [C_NASTI_ID_WIDTH-1:0]     ar_id;
    logic [C_NASTI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                      ar_len;
    logic [2:0]                      ar_size;
    logic [1:0]                      ar_burst;
    logic                            ar_valid;
    logic                            ar_ready;

    logic [C_NASTI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                      r_resp;
    logic                            r_last;
    logic [C_NASTI_ID_WIDTH-1:0]     r_id;
    logic [C_NASTI_USER_WIDTH-1:0]   r_user;
    logic                            r_valid;
    logic                            r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_id, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_id, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/nasti_mem_slave.sv
// AXI4 memory responder: word-addressed RAM behind independent write and read
// burst engines; FIXED/INCR bursts of full-width beats only, anything else gets SLVERR.
module nasti_mem_slave #(
    parameter int C_NASTI_ID_WIDTH   = 9,
    parameter int C_NASTI_ADDR_WIDTH = 32,
    parameter int C_NASTI_DATA_WIDTH = 64,
    parameter int C_NASTI_USER_WIDTH = 1,
    parameter int MEM_DEPTH          = 256
) (
    input logic   clk,
    input logic   rst,
    nasti_if.slave s
);
    localparam int          NBYTES    = C_NASTI_DATA_WIDTH / 8;
    localparam int          LSB       = $clog2(NBYTES);
    localparam int          IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [2:0]  FULL_SIZE = 3'(LSB);
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SLV  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    logic [C_NASTI_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    w_state_t                      w_state;
    logic                          aw_ready_q, w_ready_q, b_valid_q;
    logic [1:0]                    b_resp_q;
    logic [C_NASTI_ID_WIDTH-1:0]   w_id;
    logic [IDX_W-1:0]              w_idx;
    logic [7:0]                    w_len, w_cnt;
    logic                          w_incr, w_bad;

    r_state_t                      r_state;
    logic                          ar_ready_q, r_valid_q, r_last_q;
    logic [1:0]                    r_resp_q;
    logic [C_NASTI_DATA_WIDTH-1:0] r_data_q;
    logic [C_NASTI_ID_WIDTH-1:0]   r_id_q;
    logic [IDX_W-1:0]              r_idx, r_next_idx, ar_idx;
    logic [7:0]                    r_len, r_cnt;
    logic                          r_incr, r_bad, ar_bad;

    logic w_fire, w_end, mem_we;

    assign w_fire     = w_ready_q && s.w_valid;
    assign w_end      = s.w_last || (w_cnt == w_len);
    assign mem_we     = w_fire && !w_bad;
    assign ar_idx     = s.ar_addr[LSB +: IDX_W];
    assign ar_bad     = s.ar_burst[1] || (s.ar_size != FULL_SIZE);
    assign r_next_idx = r_incr ? r_idx + 1'b1 : r_idx;

    // Write engine: the burst ends on w_last or the len-th beat, whichever is first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state    <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            w_id       <= '0;
            w_idx      <= '0;
            w_len      <= '0;
            w_cnt      <= '0;
            w_incr     <= 1'b0;
            w_bad      <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_ready_q <= 1'b1;
                    if (aw_ready_q && s.aw_valid) begin
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                        w_id       <= s.aw_id;
                        w_idx      <= s.aw_addr[LSB +: IDX_W];
                        w_len      <= s.aw_len;
                        w_cnt      <= '0;
                        w_incr     <= (s.aw_burst == 2'b01);
                        w_bad      <= s.aw_burst[1] || (s.aw_size != FULL_SIZE);
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        if (w_incr)
                            w_idx <= w_idx + 1'b1;
                        if (w_end) begin
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                            b_resp_q  <= (w_bad || (s.w_last != (w_cnt == w_len)))
                                         ? RESP_SLV : RESP_OKAY;
                            w_state   <= W_RESP;
                        end else begin
                            w_cnt <= w_cnt + 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (s.b_ready) begin
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (s.w_strb[i])
                    mem[w_idx][8*i +: 8] <= s.w_data[8*i +: 8];
            end
        end
    end

    // Read engine: data is fetched on the handshake that consumes the previous beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
            r_id_q     <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_incr     <= 1'b0;
            r_bad      <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    ar_ready_q <= 1'b1;
                    if (ar_ready_q && s.ar_valid) begin
                        ar_ready_q <= 1'b0;
                        r_id_q     <= s.ar_id;
                        r_idx      <= ar_idx;
                        r_len      <= s.ar_len;
                        r_cnt      <= '0;
                        r_incr     <= (s.ar_burst == 2'b01);
                        r_bad      <= ar_bad;
                        r_valid_q  <= 1'b1;
                        r_last_q   <= (s.ar_len == 8'd0);
                        r_resp_q   <= ar_bad ? RESP_SLV : RESP_OKAY;
                        r_data_q   <= ar_bad ? '0 : mem[ar_idx];
                        r_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s.r_ready) begin
                        if (r_last_q) begin
                            r_valid_q  <= 1'b0;
                            r_last_q   <= 1'b0;
                            ar_ready_q <= 1'b1;
                            r_state    <= R_IDLE;
                        end else begin
                            r_idx    <= r_next_idx;
                            r_cnt    <= r_cnt + 1'b1;
                            r_last_q <= ((r_cnt + 8'd1) == r_len);
                            r_data_q <= r_bad ? '0 : mem[r_next_idx];
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    assign s.aw_ready = aw_ready_q;
    assign s.w_ready  = w_ready_q;
    assign s.b_valid  = b_valid_q;
    assign s.b_resp   = b_resp_q;
    assign s.b_id     = w_id;
    assign s.b_user   = '0;
    assign s.ar_ready = ar_ready_q;
    assign s.r_valid  = r_valid_q;
    assign s.r_last   = r_last_q;
    assign s.r_resp   = r_resp_q;
    assign s.r_data   = r_data_q;
    assign s.r_id     = r_id_q;
    assign s.r_user   = '0;
endmodule

// File: tb/tb_nasti_mem_slave.sv
// Directed, scoreboarded bench for nasti_mem_slave: expected B and R beats are
// queued from a reference memory model when stimulus is issued.
module tb_nasti_mem_slave;
    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [8:0]  id;
    } rbeat_t;

    typedef struct {
        logic [8:0] id;
        logic [1:0] resp;
    } bresp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int errors = 0;
    int checks = 0;

    logic [63:0] model [256];
    rbeat_t      exp_r[$];
    bresp_t      exp_b[$];

    nasti_if #(
        .C_NASTI_ID_WIDTH(9), .C_NASTI_ADDR_WIDTH(32),
        .C_NASTI_DATA_WIDTH(64), .C_NASTI_USER_WIDTH(1)
    ) s_if ();

    nasti_mem_slave #(
        .C_NASTI_ID_WIDTH(9), .C_NASTI_ADDR_WIDTH(32),
        .C_NASTI_DATA_WIDTH(64), .C_NASTI_USER_WIDTH(1), .MEM_DEPTH(256)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s(s_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int wordIdx(input logic [31:0] addr, input int beat, input logic [1:0] burst);
        return ((addr >> 3) + ((burst == 2'b01) ? beat : 0)) % 256;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Drives one write burst (aw then nbeats w beats) and queues the expected B response.
    task automatic applyStimulus(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                                 input logic [63:0] base, input logic [7:0] strb);
        int n;
        bit illegal;
        bresp_t b;
        illegal = burst[1] || (size != 3'd3);
        s_if.aw_id    = id;
        s_if.aw_addr  = addr;
        s_if.aw_len   = len;
        s_if.aw_size  = size;
        s_if.aw_burst = burst;
        s_if.aw_valid = 1'b1;
        n = 0;
        while (!s_if.aw_ready && n < 50) begin @(negedge clk); n++; end
        checkOutput("aw_ready_wait", 64'(s_if.aw_ready), 64'd1);
        @(negedge clk);
        s_if.aw_valid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_if.w_data  = base + 64'(i);
            s_if.w_strb  = strb;
            s_if.w_last  = (i == nbeats - 1);
            s_if.w_valid = 1'b1;
            n = 0;
            while (!s_if.w_ready && n < 50) begin @(negedge clk); n++; end
            checkOutput("w_ready_wait", 64'(s_if.w_ready), 64'd1);
            @(negedge clk);
            if (!illegal) begin
                for (int k = 0; k < 8; k++)
                    if (strb[k]) model[wordIdx(addr, i, burst)][8*k +: 8] = s_if.w_data[8*k +: 8];
            end
        end
        s_if.w_valid = 1'b0;
        s_if.w_last  = 1'b0;
        b.id   = id;
        b.resp = (illegal || (nbeats != int'(len) + 1)) ? 2'b10 : 2'b00;
        exp_b.push_back(b);
    endtask

    task automatic collectResp();
        int n;
        bresp_t b;
        s_if.b_ready = 1'b1;
        n = 0;
        while (!s_if.b_valid && n < 50) begin @(negedge clk); n++; end
        checkOutput("b_valid_wait", 64'(s_if.b_valid), 64'd1);
        b = exp_b.pop_front();
        checkOutput("b_id", 64'(s_if.b_id), 64'(b.id));
        checkOutput("b_resp", 64'(s_if.b_resp), 64'(b.resp));
        checkOutput("b_user", 64'(s_if.b_user), 64'd0);
        @(negedge clk);
        s_if.b_ready = 1'b0;
        checkOutput("b_valid_drop", 64'(s_if.b_valid), 64'd0);
        checkOutput("aw_ready_after_b", 64'(s_if.aw_ready), 64'd1);
    endtask

    // Issues an AR and queues the expected beats from the reference model.
    task automatic issueRead(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst);
        int n;
        bit illegal;
        rbeat_t e;
        illegal = burst[1] || (size != 3'd3);
        for (int i = 0; i <= int'(len); i++) begin
            e.data = illegal ? 64'd0 : model[wordIdx(addr, i, burst)];
            e.resp = illegal ? 2'b10 : 2'b00;
            e.last = (i == int'(len));
            e.id   = id;
            exp_r.push_back(e);
        end
        s_if.ar_id    = id;
        s_if.ar_addr  = addr;
        s_if.ar_len   = len;
        s_if.ar_size  = size;
        s_if.ar_burst = burst;
        s_if.ar_valid = 1'b1;
        n = 0;
        while (!s_if.ar_ready && n < 50) begin @(negedge clk); n++; end
        checkOutput("ar_ready_wait", 64'(s_if.ar_ready), 64'd1);
        @(negedge clk);
        s_if.ar_valid = 1'b0;
        checkOutput("r_first_latency", 64'(s_if.r_valid), 64'd1);
    endtask

    task automatic collectRead(input bit rnd, input int max_beats);
        int got = 0;
        int n = 0;
        bit stalled = 1'b0;
        logic [63:0] held = '0;
        rbeat_t e;
        while (got < max_beats && exp_r.size() > 0 && n < 3000) begin
            s_if.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_if.r_valid) begin
                if (stalled) checkOutput("r_stall_stable", s_if.r_data, held);
                if (s_if.r_ready) begin
                    e = exp_r.pop_front();
                    checkOutput("r_data", s_if.r_data, e.data);
                    checkOutput("r_resp", 64'(s_if.r_resp), 64'(e.resp));
                    checkOutput("r_last", 64'(s_if.r_last), 64'(e.last));
                    checkOutput("r_id", 64'(s_if.r_id), 64'(e.id));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = s_if.r_data;
                end
            end
            @(negedge clk);
            n++;
        end
        s_if.r_ready = 1'b0;
        checkOutput("r_beat_count", 64'(got), 64'(max_beats));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) model[i] = '0;
        s_if.aw_valid = 1'b0; s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0;
        s_if.aw_size = '0; s_if.aw_burst = '0;
        s_if.w_valid = 1'b0; s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = 1'b0;
        s_if.b_ready = 1'b0;
        s_if.ar_valid = 1'b0; s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0;
        s_if.ar_size = '0; s_if.ar_burst = '0;
        s_if.r_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("rst_aw_ready", 64'(s_if.aw_ready), 64'd0);
        checkOutput("rst_ar_ready", 64'(s_if.ar_ready), 64'd0);
        checkOutput("rst_w_ready", 64'(s_if.w_ready), 64'd0);
        checkOutput("rst_b_valid", 64'(s_if.b_valid), 64'd0);
        checkOutput("rst_r_valid", 64'(s_if.r_valid), 64'd0);
        checkOutput("rst_r_data", s_if.r_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rel_aw_ready", 64'(s_if.aw_ready), 64'd1);
        checkOutput("rel_ar_ready", 64'(s_if.ar_ready), 64'd1);
        @(negedge clk);

        $display("[TB] incr burst write/read at 0x10");
        applyStimulus(9'h05A, 32'h10, 8'd3, 3'd3, 2'b01, 4, 64'hA0, 8'hFF);
        collectResp();
        issueRead(9'h033, 32'h10, 8'd3, 3'd3, 2'b01);
        collectRead(1'b0, 4);

        $display("[TB] partial strobe write at 0x8");
        applyStimulus(9'h001, 32'h8, 8'd0, 3'd3, 2'b01, 1, 64'h0, 8'hFF);
        collectResp();
        applyStimulus(9'h002, 32'h8, 8'd0, 3'd3, 2'b01, 1, 64'h1122334455667788, 8'h0F);
        collectResp();
        issueRead(9'h003, 32'h8, 8'd0, 3'd3, 2'b01);
        collectRead(1'b0, 1);

        $display("[TB] early w_last");
        applyStimulus(9'h007, 32'h40, 8'd3, 3'd3, 2'b01, 2, 64'hB0, 8'hFF);
        checkOutput("early_last_w_ready", 64'(s_if.w_ready), 64'd0);
        collectResp();
        checkOutput("no_w_until_aw", 64'(s_if.w_ready), 64'd0);
        issueRead(9'h008, 32'h40, 8'd1, 3'd3, 2'b01);
        collectRead(1'b0, 2);

        $display("[TB] illegal size write, fixed bursts");
        applyStimulus(9'h009, 32'h10, 8'd0, 3'd2, 2'b01, 1, 64'hDEAD, 8'hFF);
        collectResp();
        issueRead(9'h00A, 32'h10, 8'd0, 3'd3, 2'b01);
        collectRead(1'b0, 1);
        applyStimulus(9'h00B, 32'h60, 8'd2, 3'd3, 2'b00, 3, 64'hC0, 8'hFF);
        collectResp();
        issueRead(9'h00C, 32'h60, 8'd2, 3'd3, 2'b00);
        collectRead(1'b0, 3);

        $display("[TB] wrap burst read");
        issueRead(9'h00D, 32'h10, 8'd1, 3'd3, 2'b10);
        collectRead(1'b0, 2);

        $display("[TB] address wrap");
        applyStimulus(9'h00E, 32'h7F8, 8'd1, 3'd3, 2'b01, 2, 64'hF0, 8'hFF);
        collectResp();
        issueRead(9'h00F, 32'h7F8, 8'd1, 3'd3, 2'b01);
        collectRead(1'b0, 2);
        issueRead(9'h010, 32'h1000, 8'd0, 3'd3, 2'b01);
        collectRead(1'b0, 1);

        $display("[TB] stalled read with concurrent write");
        applyStimulus(9'h011, 32'h100, 8'd7, 3'd3, 2'b01, 8, 64'hD0, 8'hFF);
        collectResp();
        issueRead(9'h012, 32'h100, 8'd7, 3'd3, 2'b01);
        fork
            collectRead(1'b1, 8);
            begin
                applyStimulus(9'h013, 32'h200, 8'd1, 3'd3, 2'b01, 2, 64'hE0, 8'hFF);
                collectResp();
            end
        join
        issueRead(9'h014, 32'h200, 8'd1, 3'd3, 2'b01);
        collectRead(1'b0, 2);

        $display("[TB] reset during read burst");
        issueRead(9'h044, 32'h100, 8'd7, 3'd3, 2'b01);
        collectRead(1'b0, 2);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_r_valid", 64'(s_if.r_valid), 64'd0);
        checkOutput("mid_rst_r_last", 64'(s_if.r_last), 64'd0);
        checkOutput("mid_rst_r_data", s_if.r_data, 64'd0);
        checkOutput("mid_rst_r_id", 64'(s_if.r_id), 64'd0);
        checkOutput("mid_rst_ar_ready", 64'(s_if.ar_ready), 64'd0);
        exp_r.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s_if.r_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst2_ar_ready", 64'(s_if.ar_ready), 64'd1);
        checkOutput("rst2_aw_ready", 64'(s_if.aw_ready), 64'd1);
        repeat (4) begin
            @(negedge clk);
            checkOutput("no_beats_after_rst", 64'(s_if.r_valid), 64'd0);
        end
        s_if.r_ready = 1'b0;
        issueRead(9'h045, 32'h10, 8'd3, 3'd3, 2'b01);
        collectRead(1'b0, 4);

        $display("[TB] 256-beat bursts");
        applyStimulus(9'h100, 32'h0, 8'd255, 3'd3, 2'b01, 256, 64'h1000, 8'hFF);
        collectResp();
        issueRead(9'h101, 32'h0, 8'd255, 3'd3, 2'b01);
        collectRead(1'b0, 256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
